// File: rtl/produto_escalar_ctrl.sv
// Controller for an 8-element signed dot-product engine. It loads operand vectors
// a and b, starts the engine, waits for the engine or a timeout, and holds the response.
module produto_escalar_ctrl #(
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic               wr_sel,
  input  logic signed [31:0] wr_data,
  input  logic               clr,
  input  logic               go,
  output logic               busy,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic signed [63:0] rsp_result,
  output logic               rsp_error,
  output logic               pe_start,
  input  logic               pe_done,
  input  logic signed [63:0] pe_result,
  output logic signed [31:0] pe_a0, pe_a1, pe_a2, pe_a3, pe_a4, pe_a5, pe_a6, pe_a7,
  output logic signed [31:0] pe_b0, pe_b1, pe_b2, pe_b3, pe_b4, pe_b5, pe_b6, pe_b7
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic signed [31:0] vec_a_q [8];
  logic signed [31:0] vec_a_d [8];
  logic signed [31:0] vec_b_q [8];
  logic signed [31:0] vec_b_d [8];
  logic [TW-1:0]      tmo_q, tmo_d;
  logic signed [63:0] res_q, res_d;
  logic               err_q, err_d;

  logic go_ok, clr_ok, wr_fire, tmo_last;

  // go needs both vectors full; an accepted go outranks clr, and clr outranks a write.
  assign go_ok    = (state_q == S_LOAD) && go && (cnt_a_q == 4'd8) && (cnt_b_q == 4'd8);
  assign clr_ok   = (state_q == S_LOAD) && clr && !go_ok;
  assign wr_ready = (state_q == S_LOAD) && (wr_sel ? (cnt_b_q < 4'd8) : (cnt_a_q < 4'd8));
  assign wr_fire  = wr_valid && wr_ready && !clr_ok;
  assign tmo_last = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= S_LOAD;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      // NOTE: the operand registers are reset because the engine sees them directly after reset.
      vec_a_q <= '{default: '0};
      vec_b_q <= '{default: '0};
      tmo_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      vec_a_q <= vec_a_d;
      vec_b_q <= vec_b_d;
      tmo_q   <= tmo_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (go_ok) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (pe_done || tmo_last) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a hold default first so no latch is inferred on untaken paths.
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    vec_a_d = vec_a_q;
    vec_b_d = vec_b_q;
    tmo_d   = tmo_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_LOAD: begin
        if (clr_ok) begin
          cnt_a_d = '0;
          cnt_b_d = '0;
        end else if (wr_fire) begin
          if (wr_sel) begin
            vec_b_d[cnt_b_q[2:0]] = wr_data;
            cnt_b_d = cnt_b_q + 4'd1;
          end else begin
            vec_a_d[cnt_a_q[2:0]] = wr_data;
            cnt_a_d = cnt_a_q + 4'd1;
          end
        end
      end
      S_START: tmo_d = '0;
      S_WAIT: begin
        if (pe_done) begin
          res_d = pe_result;
          err_d = 1'b0;
        end else if (tmo_last) begin
          res_d = '0;
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          cnt_a_d = '0;
          cnt_b_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pe_start  = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_START: begin
        pe_start = 1'b1;
        busy     = 1'b1;
      end
      S_WAIT:  busy      = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_result = res_q;
  assign rsp_error  = err_q;

  assign pe_a0 = vec_a_q[0];
  assign pe_a1 = vec_a_q[1];
  assign pe_a2 = vec_a_q[2];
  assign pe_a3 = vec_a_q[3];
  assign pe_a4 = vec_a_q[4];
  assign pe_a5 = vec_a_q[5];
  assign pe_a6 = vec_a_q[6];
  assign pe_a7 = vec_a_q[7];
  assign pe_b0 = vec_b_q[0];
  assign pe_b1 = vec_b_q[1];
  assign pe_b2 = vec_b_q[2];
  assign pe_b3 = vec_b_q[3];
  assign pe_b4 = vec_b_q[4];
  assign pe_b5 = vec_b_q[5];
  assign pe_b6 = vec_b_q[6];
  assign pe_b7 = vec_b_q[7];

endmodule

// File: doc/produto_escalar_ctrl.md
PRODUTO_ESCALAR_CTRL -- requirements
Module: produto_escalar_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 32, max cycles in WAIT for pe_done before error response.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wr_valid  input  1  element write request.
REQ-005 wr_ready  output  1  element write accepted when wr_valid&wr_ready.
REQ-006 wr_sel  input  1  target vector: 0=a, 1=b.
REQ-007 wr_data  input  32  signed element value.
REQ-008 clr  input  1  discard loaded elements (LOAD only).
REQ-009 go  input  1  request computation.
REQ-010 busy  output  1  high in START and WAIT.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid&rsp_ready.
REQ-013 rsp_result  output  64  signed dot product.
REQ-014 rsp_error  output  1  response produced by timeout.
REQ-015 pe_start  output  1  start to dot-product engine.
REQ-016 pe_done  input  1  engine completion pulse.
REQ-017 pe_result  input  64  signed engine result.
REQ-018 pe_a0..pe_a7, pe_b0..pe_b7  output  32 each  signed operand vectors.

Function
REQ-019 FSM states SHALL be LOAD, START, WAIT, RESP; reset state LOAD.
REQ-020 Separate 4-bit counters cnt_a, cnt_b (0..8) SHALL track loaded elements.
REQ-021 wr_ready = (state==LOAD) && count of vector selected by wr_sel < 8; combinational on wr_sel.
REQ-022 Accepted write SHALL store wr_data at index cnt_sel of the selected vector, then increment cnt_sel.
REQ-023 Writes outside LOAD or to a full vector SHALL not be accepted, with no state change.
REQ-024 clr in LOAD SHALL zero cnt_a and cnt_b; vector contents retained; clr outside LOAD ignored.
REQ-025 clr and write in the same cycle: clr wins, write dropped (wr_ready still reflects pre-clr counts; write dropped regardless).
REQ-026 go in LOAD with cnt_a==8 and cnt_b==8 (pre-write values) SHALL move to START; otherwise go ignored; go outside LOAD ignored.
REQ-027 go accepted takes priority over clr in the same cycle.
REQ-028 START: pe_start=1 for exactly one cycle, then WAIT; timeout counter cleared.
REQ-029 pe_a*/pe_b* SHALL be driven continuously from the vector registers and SHALL not change in START, WAIT, RESP.
REQ-030 pe_done SHALL be sampled only in WAIT; pe_done in any other state ignored.
REQ-031 WAIT with pe_done=1: capture pe_result into rsp_result, rsp_error=0, go to RESP.
REQ-032 WAIT counter increments each cycle without pe_done; on reaching TIMEOUT: rsp_result=0, rsp_error=1, go to RESP.
REQ-033 RESP: rsp_valid=1; rsp_result/rsp_error stable until handshake.
REQ-034 RESP handshake SHALL clear rsp_valid, zero cnt_a/cnt_b, return to LOAD next cycle.
REQ-035 rsp_result/rsp_error SHALL hold last values after handshake until next capture.
REQ-036 Latency, with produto_escalar as engine: rsp_valid high 10 cycles after the go-acceptance cycle.
REQ-037 No arithmetic in this block; result passed through bit-exact, 64-bit two's complement.

Reset
REQ-038 rst SHALL take effect on the clk edge, overriding all other inputs.
REQ-039 After reset: state LOAD, cnt_a=cnt_b=0, vector registers 0, pe_start=0, busy=0, rsp_valid=0, rsp_result=0, rsp_error=0, timeout counter 0, wr_ready=1.
REQ-040 Reset in START/WAIT/RESP SHALL abort; a later pe_done SHALL be ignored.

Verification
REQ-041 Load a=1..8, b=1..8, go -> pe_start one-cycle pulse; rsp_valid after 10 cycles; rsp_result=204, rsp_error=0.
REQ-042 a_i=-3, b_i=5 for all i, interleaved a/b writes -> rsp_result=0xFFFF_FFFF_FFFF_FF88 (-120).
REQ-043 Load 8 a and 7 b, go -> ignored, busy stays 0; 9th a write -> wr_ready=0 for wr_sel=0.
REQ-044 Hold pe_done=0 after start -> RESP after 32 WAIT cycles with rsp_error=1, rsp_result=0; later pe_done ignored.
REQ-045 rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_result stable; wr_ready=0; go ignored until handshake.
REQ-046 rst asserted mid-WAIT -> next cycle all REQ-039 values; subsequent pe_done produces no response.
